// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, funct3
// access encodings and the byte-enable width of the data-memory port.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int BE_WIDTH = 4;

  // The low two funct3 bits encode the access size for loads and stores alike.
  function automatic logic f3_legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load data extraction: shifts the addressed byte/half into the
// low lanes and sign- or zero-extends it according to funct3.
module load_extend
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic [1:0]            offset,
  input  logic [2:0]            funct3,
  output logic [DATA_WIDTH-1:0] ext_data
);

  logic [DATA_WIDTH-1:0] shifted;

  always_comb begin
    shifted = mem_rdata >> {offset, 3'b000};
    case (funct3)
      F3_B:    ext_data = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
      F3_H:    ext_data = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      F3_BU:   ext_data = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
      F3_HU:   ext_data = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
      default: ext_data = mem_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: validates load/store requests, drives a registered
// ready/request bus transaction with byte enables and stalls the core meanwhile.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] ALUResult,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic [2:0]            funct3,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  stall,
  output logic                  fault,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [BE_WIDTH-1:0]   mem_be,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  lsu_state_t            state;
  logic                  misaligned;
  logic                  valid_access;
  logic [1:0]            offset;
  logic [BE_WIDTH-1:0]   next_be;
  logic [DATA_WIDTH-1:0] next_wdata;
  logic [1:0]            off_q;
  logic [2:0]            f3_q;
  logic [DATA_WIDTH-1:0] ext_data;

  assign offset = ALUResult[1:0];

  always_comb begin
    misaligned   = ((funct3[1:0] == 2'b01) && ALUResult[0]) ||
                   ((funct3[1:0] == 2'b10) && (ALUResult[1:0] != 2'b00));
    valid_access = (MemRead ^ MemWrite) && f3_legal(funct3) && !misaligned;
    stall        = ((state == IDLE) && valid_access) || (state == BUSY);
    fault        = (state == IDLE) && (MemRead || MemWrite) && !valid_access;
  end

  // Narrow stores are replicated across every lane so the enables alone pick the bytes.
  always_comb begin
    case (funct3[1:0])
      2'b00: begin
        next_be    = 4'b0001 << offset;
        next_wdata = {4{WriteData[7:0]}};
      end
      2'b01: begin
        next_be    = 4'b0011 << offset;
        next_wdata = {2{WriteData[15:0]}};
      end
      default: begin
        next_be    = 4'b1111;
        next_wdata = WriteData;
      end
    endcase
  end

  load_extend #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_load_extend (
    .mem_rdata(mem_rdata),
    .offset   (off_q),
    .funct3   (f3_q),
    .ext_data (ext_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      ReadData  <= '0;
      off_q     <= 2'b00;
      f3_q      <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          if (valid_access) begin
            state     <= BUSY;
            mem_req   <= 1'b1;
            mem_we    <= MemWrite;
            mem_addr  <= {ALUResult[ADDR_WIDTH-1:2], 2'b00};
            mem_wdata <= next_wdata;
            mem_be    <= next_be;
            off_q     <= offset;
            f3_q      <= funct3;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            if (!mem_we) begin
              ReadData <= ext_data;
            end
            state     <= DONE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage that sits between the execute stage and an external data-memory port. It accepts the execute stage's address (`ALUResult`) and store data (`WriteData`) and turns loads and stores into a ready/request bus transaction with byte enables. While the access is outstanding it stalls the core. It then returns a sign- or zero-extended `ReadData` that feeds the writeback `Result` mux.

## Interface
Parameters:
- `DATA_WIDTH`, 32, data path width (only 32 supported)
- `ADDR_WIDTH`, 32, byte address width

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `ALUResult`  in  ADDR_WIDTH  byte address from execute
- `WriteData`  in  DATA_WIDTH  store data (rs2)
- `funct3`  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- `MemRead`  in  1  load request
- `MemWrite`  in  1  store request
- `ReadData`  out  DATA_WIDTH  extended load result
- `stall`  out  1  freeze PC and pipeline
- `fault`  out  1  one-cycle pulse: misaligned, illegal funct3, or MemRead&MemWrite
- `mem_req`  out  1  bus request
- `mem_we`  out  1  1 = write
- `mem_addr`  out  ADDR_WIDTH  word-aligned address (`[1:0]`=00)
- `mem_wdata`  out  DATA_WIDTH  lane-replicated store data
- `mem_be`  out  4  byte enables
- `mem_ready`  in  1  memory accepts/completes in this cycle
- `mem_rdata`  in  DATA_WIDTH  read word, valid when `mem_ready`=1

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - Valid access (`MemRead` xor `MemWrite`, legal funct3, aligned) → register addr/we/wdata/be, go to BUSY. `stall`=1 in this cycle.
  - Invalid access → `fault`=1 for this cycle, `stall`=0, no bus access, stay IDLE.
  - Halfword is misaligned if `addr[0]`=1. Word is misaligned if `addr[1:0]`≠00. funct3 011/110/111 is illegal for both loads and stores.
- BUSY: `mem_req`=1, `stall`=1. On `mem_ready`=1, capture the extended `mem_rdata` into `ReadData` (loads only) and go to DONE.
- DONE: `stall`=0, `ReadData` valid. The pipeline advances at this edge. Go to IDLE unconditionally; no new access is accepted in DONE.
- Store lanes, with o = `addr[1:0]`:
  - SB: `be`=0001<<o, wdata = byte replicated ×4.
  - SH: `be`=0011<<o, wdata = half replicated ×2.
  - SW: `be`=1111.
- Load extract: `word >> (8*o)`.
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes the word.
- Stores leave `ReadData` unchanged.

## Timing
- Reset values:
  - state IDLE.
  - `mem_req`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata`, `ReadData`, `fault` all 0.
  - `stall` is 0 with request inputs low.
- `rst` mid-transaction: `mem_req` drops asynchronously, state returns to IDLE, and the transaction is abandoned.
- Minimum access is 3 cycles: request seen (IDLE), BUSY with `mem_ready`=1, DONE. `stall` is high for 2 cycles.
- Each BUSY cycle with `mem_ready`=0 adds one cycle.
- `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` and `mem_be` are registered and held stable for the whole BUSY period. They clear to 0 on leaving BUSY.
- `mem_ready` is ignored outside BUSY.
- `stall` = (IDLE & valid access) | BUSY. It is combinational from the request inputs.
- `fault` is combinational in IDLE and is never asserted in BUSY or DONE.

## Structure
- `lsu_pkg`: state enum, funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`), byte-enable width.
- Sub-module `load_extend` (combinational): takes `mem_rdata`, `addr[1:0]` and `funct3`, and produces the extended data.
- FSM, lane steering and the registers live in `load_store_unit`.

## Test plan
- **SW/LW:**
  - Store SW addr 0x100, data 0xDEADBEEF, with `mem_ready` tied 1 → `mem_addr`=0x100, `be`=1111, `stall` high 2 cycles.
  - Then LW 0x100 with rdata 0xDEADBEEF → `ReadData`=0xDEADBEEF in DONE.
- **SB lane steering:** SB addr 0x103, data 0x000000A5 → `mem_addr`=0x100, `be`=1000, `wdata`=0xA5A5A5A5.
- **LB/LBU/LH:** rdata 0x80FF7F01.
  - LB @+2 → 0xFFFFFFFF.
  - LBU @+3 → 0x00000080.
  - LH @+2 → 0xFFFF80FF.
- **Wait states:** LW with `mem_ready` low for 3 BUSY cycles → `stall` high 5 cycles, `mem_*` stable throughout, `ReadData` correct in DONE.
- **Faults:**
  - LW @0x102 → `fault` pulse, `mem_req` never asserted, `stall`=0.
  - funct3=011 → `fault` pulse.
  - `MemRead`&`MemWrite` both high → `fault` pulse.
- **Async reset:** assert `rst` in the 2nd BUSY cycle → `mem_req` falls without a clock edge, all outputs return to reset values, and the next LW completes normally.
